// File: rtl/keypad_event_decoder_if.sv
// rtl/keypad_event_decoder_if.sv - key event valid/ready handshake bundle
interface keypad_event_decoder_if;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] key_code;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_event_decoder.sv
// rtl/keypad_event_decoder.sv - keypad debouncer, key encoder and event FIFO
module keypad_event_decoder #(
  parameter int DEBOUNCE_CYC = 320000,
  parameter int RELEASE_CYC  = 320000,
  parameter int CNT_W        = 19,
  parameter int FIFO_DEPTH   = 4,
  parameter int PTR_W        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [11:0]           key_data,
  keypad_event_decoder_if.master evt,
  output logic                  key_held,
  output logic [PTR_W:0]        key_count,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam int CW = PTR_W + 1;
  localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CW-1:0]    FULL_COUNT   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]    COUNT_ONE    = CW'(1);
  localparam logic [PTR_W-1:0] PTR_ONE      = PTR_W'(1);

  // '0' sits on bit 10 and '*'/'#' follow the digits, so the map is not a plain index
  function automatic logic [3:0] encode(input logic [11:0] onehot);
    logic [3:0] code;
    code = 4'h0;
    for (int i = 0; i < 9; i++) begin
      if (onehot[i]) code = 4'(i + 1);
    end
    if (onehot[9])  code = 4'hA;
    if (onehot[11]) code = 4'hB;
    return code;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [11:0]        cand_q, cand_d;
  logic               push_req;
  logic               valid_sample;
  logic               match;

  logic [3:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic               overflow_q;
  logic               empty;
  logic               full;
  logic               pop;
  logic               do_push;
  logic               drop;

  assign valid_sample = (key_data != 12'd0) && ((key_data & (key_data - 12'd1)) == 12'd0);
  // candidate is always one-hot while it matters, so equality also rejects multi-hot input
  assign match        = (key_data == cand_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    push_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_sample) begin
          cand_d  = key_data;
          cnt_d   = CNT_ONE;
          state_d = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!match) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == PRESS_LAST) begin
          push_req = 1'b1;
          cnt_d    = '0;
          state_d  = HELD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!match) begin
          cnt_d   = CNT_ONE;
          state_d = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (match) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_q == RELEASE_LAST) begin
          cnt_d   = '0;
          cand_d  = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        cand_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_COUNT);
  assign pop     = !empty && evt.key_ready;
  // a full queue still accepts the push when the head leaves on the same edge
  assign do_push = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 4'h0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= encode(cand_q);
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, pop})
        2'b10:   count_q <= count_q + COUNT_ONE;
        2'b01:   count_q <= count_q - COUNT_ONE;
        default: count_q <= count_q;
      endcase
      overflow_q <= drop;
    end
  end

  assign evt.key_valid = !empty;
  assign evt.key_code  = empty ? 4'h0 : mem_q[rd_ptr_q];
  assign key_held      = (state_q == HELD) || (state_q == RELEASE_WAIT);
  assign key_count     = count_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_keypad_event_decoder.sv
// tb/tb_keypad_event_decoder.sv - self-checking bench for keypad_event_decoder
module tb_keypad_event_decoder;
  localparam int DEB   = 4;
  localparam int REL   = 4;
  localparam int DEPTH = 4;
  localparam int PW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [11:0]   key_data = 12'd0;
  logic          key_held;
  logic [PW:0]   key_count;
  logic          overflow;
  int            errors = 0;
  int            checks = 0;

  keypad_event_decoder_if evt();

  keypad_event_decoder #(
    .DEBOUNCE_CYC(DEB),
    .RELEASE_CYC (REL),
    .CNT_W       (3),
    .FIFO_DEPTH  (DEPTH),
    .PTR_W       (PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_data (key_data),
    .evt      (evt),
    .key_held (key_held),
    .key_count(key_count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // reference model: run lengths of matching / non-matching samples plus a code queue
  bit          m_latched;
  logic [11:0] m_cand;
  int          m_run;
  int          m_off;
  bit          m_ovf;
  logic [3:0]  m_q [$];

  function automatic logic [3:0] code_of(input logic [11:0] kd);
    logic [3:0] tab [12];
    tab = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'h0, 4'hB};
    for (int i = 0; i < 12; i++) if (kd[i]) return tab[i];
    return 4'h0;
  endfunction

  task automatic model_reset();
    m_latched = 0;
    m_cand    = 12'd0;
    m_run     = 0;
    m_off     = 0;
    m_ovf     = 0;
    m_q.delete();
  endtask

  task automatic tick(input logic [11:0] kd, input logic rdy);
    bit popped;
    bit ev;
    key_data      = kd;
    evt.key_ready = rdy;
    @(posedge clk);
    popped = (m_q.size() > 0) && rdy;
    ev     = 0;
    if (!m_latched) begin
      if (m_cand == 12'd0) begin
        if ($countones(kd) == 1) begin
          m_cand = kd;
          m_run  = 1;
        end
      end else if (kd == m_cand) begin
        m_run++;
        if (m_run == DEB) begin
          ev        = 1;
          m_latched = 1;
          m_off     = 0;
        end
      end else begin
        m_cand = 12'd0;
        m_run  = 0;
      end
    end else if (kd == m_cand) begin
      m_off = 0;
    end else begin
      m_off++;
      if (m_off == REL) begin
        m_latched = 0;
        m_cand    = 12'd0;
        m_off     = 0;
      end
    end
    m_ovf = ev && (m_q.size() == DEPTH) && !popped;
    if (popped) void'(m_q.pop_front());
    if (ev && !m_ovf) m_q.push_back(code_of(m_cand));
    #1;
  endtask

  task automatic press_release(input logic [11:0] kd, input logic rdy);
    repeat (DEB) tick(kd, rdy);
    repeat (REL) tick(12'd0, rdy);
  endtask

  task automatic test_reset();
    evt.key_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    checks++; if (evt.key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", evt.key_valid); end
    checks++; if (evt.key_code !== 4'h0) begin errors++; $display("FAIL reset_code: got %0h expected 0", evt.key_code); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %0b expected 0", key_held); end
    checks++; if (key_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", key_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single_press();
    for (int i = 1; i <= 10; i++) begin
      tick(12'h010, 1'b0);
      if (i == 3) begin
        checks++; if (evt.key_valid !== 1'b0) begin errors++; $display("FAIL single_early: got valid=%0b expected 0", evt.key_valid); end
      end
      if (i == 4) begin
        checks++;
        if ({evt.key_valid, evt.key_code, key_count, key_held} !== {1'b1, 4'h5, 3'd1, 1'b1}) begin
          errors++;
          $display("FAIL single_push: got v=%0b c=%0h n=%0d h=%0b expected v=1 c=5 n=1 h=1",
                   evt.key_valid, evt.key_code, key_count, key_held);
        end
      end
    end
    checks++; if (key_count !== 3'd1) begin errors++; $display("FAIL single_no_repeat: got count=%0d expected 1", key_count); end
    tick(12'h010, 1'b1);
    checks++;
    if ({evt.key_valid, key_count} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL single_pop: got v=%0b n=%0d expected v=0 n=0", evt.key_valid, key_count);
    end
    for (int i = 1; i <= REL; i++) begin
      tick(12'd0, 1'b0);
      if (i == REL - 1) begin
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL single_held_before_release: got %0b expected 1", key_held); end
      end
    end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL single_released: got %0b expected 0", key_held); end
  endtask

  task automatic test_press_bounce();
    tick(12'h001, 1'b0);
    tick(12'h001, 1'b0);
    tick(12'h000, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick(12'h001, 1'b0);
      if (i == 3) begin
        checks++; if (evt.key_valid !== 1'b0) begin errors++; $display("FAIL bounce_early: got valid=%0b expected 0", evt.key_valid); end
      end
      if (i == 4) begin
        checks++;
        if ({evt.key_valid, evt.key_code} !== {1'b1, 4'h1}) begin
          errors++; $display("FAIL bounce_push: got v=%0b c=%0h expected v=1 c=1", evt.key_valid, evt.key_code);
        end
      end
    end
    checks++; if (key_count !== 3'd1) begin errors++; $display("FAIL bounce_count: got %0d expected 1", key_count); end
    tick(12'd0, 1'b1);
    repeat (REL - 1) tick(12'd0, 1'b0);
    checks++;
    if ({key_count, key_held} !== {3'd0, 1'b0}) begin
      errors++; $display("FAIL bounce_idle: got n=%0d h=%0b expected n=0 h=0", key_count, key_held);
    end
  endtask

  task automatic test_invalid();
    for (int i = 0; i < 20; i++) begin
      tick(12'h003, 1'b0);
      checks++;
      if ({evt.key_valid, key_held} !== 2'b00) begin
        errors++; $display("FAIL multihot_cycle%0d: got v=%0b h=%0b expected 0 0", i, evt.key_valid, key_held);
      end
    end
    tick(12'd0, 1'b0);
  endtask

  task automatic test_release_bounce();
    repeat (DEB) tick(12'h400, 1'b0);
    checks++;
    if ({evt.key_valid, evt.key_code} !== {1'b1, 4'h0}) begin
      errors++; $display("FAIL relb_first: got v=%0b c=%0h expected v=1 c=0", evt.key_valid, evt.key_code);
    end
    repeat (2) tick(12'd0, 1'b0);
    repeat (3) tick(12'h400, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick(12'd0, 1'b0);
      if (i == 3) begin
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL relb_held3: got %0b expected 1", key_held); end
      end
      if (i == 4) begin
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL relb_fall4: got %0b expected 0", key_held); end
      end
    end
    checks++; if (key_count !== 3'd1) begin errors++; $display("FAIL relb_single: got %0d expected 1", key_count); end
    repeat (DEB) tick(12'h400, 1'b0);
    checks++;
    if ({key_count, evt.key_code} !== {3'd2, 4'h0}) begin
      errors++; $display("FAIL relb_second: got n=%0d c=%0h expected n=2 c=0", key_count, evt.key_code);
    end
    repeat (REL) tick(12'd0, 1'b1);
    checks++; if (key_count !== 3'd0) begin errors++; $display("FAIL relb_drain: got %0d expected 0", key_count); end
  endtask

  task automatic test_overflow();
    logic [11:0] keys [5];
    logic [3:0]  exp_codes [4];
    keys      = '{12'h001, 12'h002, 12'h004, 12'h200, 12'h800};
    exp_codes = '{4'h1, 4'h2, 4'h3, 4'hA};
    for (int k = 0; k < 5; k++) begin
      repeat (DEB) tick(keys[k], 1'b0);
      checks++;
      if (k < 4) begin
        if ({key_count, overflow} !== {3'(k + 1), 1'b0}) begin
          errors++; $display("FAIL ovf_fill%0d: got n=%0d o=%0b expected n=%0d o=0", k, key_count, overflow, k + 1);
        end
      end else if ({key_count, overflow} !== {3'd4, 1'b1}) begin
        errors++; $display("FAIL ovf_drop: got n=%0d o=%0b expected n=4 o=1", key_count, overflow);
      end
      tick(12'd0, 1'b0);
      if (k == 4) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse_width: got %0b expected 0", overflow); end
      end
      repeat (REL - 1) tick(12'd0, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({evt.key_valid, evt.key_code} !== {1'b1, exp_codes[k]}) begin
        errors++; $display("FAIL ovf_drain%0d: got v=%0b c=%0h expected v=1 c=%0h", k, evt.key_valid, evt.key_code, exp_codes[k]);
      end
      tick(12'd0, 1'b1);
    end
    checks++;
    if ({evt.key_valid, evt.key_code, key_count} !== {1'b0, 4'h0, 3'd0}) begin
      errors++; $display("FAIL ovf_empty: got v=%0b c=%0h n=%0d expected 0 0 0", evt.key_valid, evt.key_code, key_count);
    end
  endtask

  task automatic test_full_push_pop();
    logic [3:0] exp_codes [4];
    exp_codes = '{4'h2, 4'h3, 4'h4, 4'hB};
    press_release(12'h001, 1'b0);
    press_release(12'h002, 1'b0);
    press_release(12'h004, 1'b0);
    press_release(12'h008, 1'b0);
    repeat (DEB - 1) tick(12'h800, 1'b0);
    tick(12'h800, 1'b1);
    checks++;
    if ({key_count, overflow, evt.key_code} !== {3'd4, 1'b0, 4'h2}) begin
      errors++; $display("FAIL pushpop_full: got n=%0d o=%0b c=%0h expected n=4 o=0 c=2", key_count, overflow, evt.key_code);
    end
    repeat (REL) tick(12'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (evt.key_code !== exp_codes[k]) begin
        errors++; $display("FAIL pushpop_drain%0d: got %0h expected %0h", k, evt.key_code, exp_codes[k]);
      end
      tick(12'd0, 1'b1);
    end
    checks++; if (evt.key_valid !== 1'b0) begin errors++; $display("FAIL pushpop_empty: got %0b expected 0", evt.key_valid); end
  endtask

  task automatic test_reset_mid();
    press_release(12'h001, 1'b0);
    press_release(12'h002, 1'b0);
    tick(12'h020, 1'b0);
    tick(12'h020, 1'b0);
    checks++; if (key_count !== 3'd2) begin errors++; $display("FAIL midrst_pre: got %0d expected 2", key_count); end
    rst = 1'b1;
    #2;
    checks++;
    if ({evt.key_valid, key_count, key_held} !== {1'b0, 3'd0, 1'b0}) begin
      errors++; $display("FAIL midrst_clear: got v=%0b n=%0d h=%0b expected 0 0 0", evt.key_valid, key_count, key_held);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 1; i <= DEB; i++) begin
      tick(12'h020, 1'b0);
      if (i == DEB - 1) begin
        checks++; if (evt.key_valid !== 1'b0) begin errors++; $display("FAIL midrst_early: got %0b expected 0", evt.key_valid); end
      end
    end
    checks++;
    if ({evt.key_valid, evt.key_code, key_count} !== {1'b1, 4'h6, 3'd1}) begin
      errors++; $display("FAIL midrst_event: got v=%0b c=%0h n=%0d expected 1 6 1", evt.key_valid, evt.key_code, key_count);
    end
    repeat (REL) tick(12'd0, 1'b1);
  endtask

  task automatic test_random();
    logic [11:0] kd;
    logic [9:0]  got;
    logic [9:0]  exp;
    int          sel;
    int          a;
    for (int seg = 0; seg < 80; seg++) begin
      sel = int'($urandom_range(0, 5));
      a   = int'($urandom_range(0, 11));
      if (sel == 0)      kd = 12'd0;
      else if (sel == 5) kd = (12'h1 << a) | (12'h1 << ((a + 1 + int'($urandom_range(0, 10))) % 12));
      else               kd = 12'h1 << (a % 4);
      repeat ($urandom_range(1, 7)) begin
        tick(kd, ($urandom_range(0, 3) == 0));
        got = {evt.key_valid, evt.key_code, key_held, key_count, overflow};
        exp = {(m_q.size() != 0), (m_q.size() != 0) ? m_q[0] : 4'h0, m_latched, 3'(m_q.size()), m_ovf};
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL random_seg%0d kd=%03h: got %03h expected %03h", seg, kd, got, exp);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    evt.key_ready = 1'b0;
    test_reset();
    test_single_press();
    test_press_bounce();
    test_invalid();
    test_release_bounce();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keypad_event_decoder.md
Name: keypad_event_decoder

Overview:
- Consumes the 12-bit one-hot `key_data` bus produced by the keypad column scanner.
- Debounces press and release, then encodes each accepted press into a 4-bit key code.
- Queues codes in a small FIFO and presents them to downstream logic (digit entry, display, control FSM) via a valid/ready handshake.
- Produces exactly one event per physical press, regardless of how long the key is held.

Parameters:
- DEBOUNCE_CYC, 320000: consecutive identical one-hot samples required to accept a press (20 ms at 16 MHz).
- RELEASE_CYC, 320000: consecutive non-matching samples required to accept a release.
- CNT_W, 19: debounce counter width; must hold max(DEBOUNCE_CYC, RELEASE_CYC)-1.
- FIFO_DEPTH, 4: event queue depth, power of two.
- PTR_W, 2: log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock, 16 MHz.
- rst  input  1  reset; one clock, asynchronous, active-high.
- key_data  input  12  one-hot key bus from the scanner; 0 means no key.
- key_ready  input  1  downstream accepts the head code this cycle.
- key_valid  output  1  FIFO non-empty; key_code is valid.
- key_code  output  4  head-of-FIFO code; 4'h0 when empty.
- key_held  output  1  high while in HELD or RELEASE_WAIT.
- key_count  output  PTR_W+1  number of queued codes.
- overflow  output  1  one-cycle pulse when an accepted press is dropped because the FIFO is full.

Behaviour:
- Reset (async):
  - state=IDLE, counter=0, candidate=0.
  - FIFO emptied; pointers=0, key_count=0.
  - key_valid=0, key_code=4'h0, key_held=0, overflow=0.
- Code map (key_data bit -> key_code):
  - bits 0..8 -> 4'h1..4'h9 (bit n -> n+1).
  - bit 9 ('*') -> 4'hA.
  - bit 10 ('0') -> 4'h0.
  - bit 11 ('#') -> 4'hB.
- Valid sample: key_data has exactly one bit set. Multi-hot values are treated as "no key" in every state.
- FSM, all transitions registered on posedge clk:
  - IDLE:
    - Valid sample -> latch candidate=key_data, counter=1, go to PRESS_WAIT.
    - Otherwise stay.
  - PRESS_WAIT:
    - key_data==candidate and counter==DEBOUNCE_CYC-1 -> push the candidate's code, go to HELD.
    - key_data==candidate otherwise -> counter+1.
    - key_data!=candidate (zero, other key, multi-hot) -> IDLE, counter=0.
  - HELD:
    - key_data==candidate -> stay; no further events (no auto-repeat).
    - Otherwise -> RELEASE_WAIT, counter=1.
  - RELEASE_WAIT:
    - key_data==candidate -> HELD (bounce), counter=0, no event.
    - Otherwise, counter==RELEASE_CYC-1 -> IDLE, candidate=0.
    - Otherwise -> counter+1.
- Press latency: the push occurs on the edge that samples the candidate for the DEBOUNCE_CYC-th consecutive time.
  - key_code/key_valid come combinationally from FIFO storage, so with an empty FIFO, key_valid is high from that edge onward.
- A different one-hot key during HELD/RELEASE_WAIT counts as "not candidate". The new key is only considered after the return to IDLE.
- FIFO:
  - Pop on key_valid & key_ready.
  - Push when full and pop in the same cycle -> both happen; count unchanged, no overflow.
  - Push when full and no pop -> code dropped, overflow=1 for that cycle, FSM still advances to HELD.
  - key_ready while empty -> ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation:
  - All state and queued codes are discarded.
  - A key still held after reset deasserts is debounced and reported as a new event.

Test Plan (DEBOUNCE_CYC=4, RELEASE_CYC=4, FIFO_DEPTH=4):
1. key_data=12'h010 for 10 cycles, key_ready=0:
   - key_valid rises on the 4th sampling edge with key_code=4'h5, key_count=1, key_held=1.
   - Only one event is queued.
   - Pulsing key_ready for 1 cycle -> key_valid=0, key_count=0.
2. Press bounce: 12'h001 for 2 cycles, 0 for 1 cycle, 12'h001 for 6 cycles -> exactly one event, code 4'h1, pushed on the 4th edge after the restart.
3. Invalid input: 12'h003 (multi-hot) for 20 cycles -> state stays IDLE, no event, key_held=0.
4. Release bounce:
   - Hold 12'h400 -> event 4'h0.
   - Then 0 for 2 cycles, 12'h400 for 3 cycles, 0 for 5 cycles -> no second event; key_held falls after the 4th zero.
   - Pressing again -> second event 4'h0.
5. Overflow: key_ready=0; press/release 12'h001, 002, 004, 200, 800 in sequence.
   - The first four are stored; the 5th is dropped with a 1-cycle overflow pulse; key_count=4.
   - Draining with key_ready=1 yields 1, 2, 3, A in order, then key_valid=0.
6. Reset mid-operation: assert rst during PRESS_WAIT with 2 codes queued.
   - Immediately key_valid=0, key_count=0, key_held=0.
   - With 12'h020 still held after rst drops -> event 4'h6 after 4 cycles.
